vga_scan_controller: RTL and testbench
======================================

# vga_scan_controller

Generates 640x480@60 Hz VGA scan timing for the game display and drives the `iAddress` input of `game_render_controller`. It accepts the renderer's 24-bit `oPixel` and delays sync and blanking to match the renderer's pipeline latency, so the DAC receives aligned RGB, sync and blank. It sits between the renderer and the board's VGA DAC pins.

## Interface
- `CLK_DIV`, 2: `iClock` cycles per pixel (50 MHz in, 25 MHz pixel); must be ≥2.
- `H_VISIBLE`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal timing in pixels.
- `V_VISIBLE`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical timing in lines.
- `PIPE_TICKS`, 1: pixel ticks from an `oAddress` change to its `iPixel` being valid at the next tick; range 1..4.
- `iClock`  in  1: system clock; the only clock.
- `iResetN`  in  1: asynchronous, active-low reset.
- `iPixel`  in  24: {R,G,B} from the renderer for the address issued `PIPE_TICKS` ticks earlier.
- `oAddress`  out  19: linear pixel address y*640+x presented to the renderer.
- `oVGAR`, `oVGAG`, `oVGAB`  out  8 each: colour to the DAC.
- `oHSync`, `oVSync`  out  1: active-low sync.
- `oBlankN`  out  1: high during the visible region.
- `oSyncN`  out  1: constant 0.
- `oVGAClock`  out  1: DAC pixel clock.
- `oFrameStart`  out  1: one-`iClock` pulse when pixel (0,0) is issued.

## Operation
- **Phase counter** `phase`: counts 0..CLK_DIV-1. A pixel tick occurs on the `iClock` cycle where `phase == CLK_DIV-1`. All scan state below changes only on ticks.
- **Horizontal counter** `h`: 0..799, wraps to 0.
- **Vertical counter** `v`: 0..524. It increments when `h` wraps and itself wraps to 0 after 524.
- **Visible region**: `h < 640` and `v < 480`.
- **Address counter** `addr`: increments on every visible tick and wraps to 0 at 307200.
  - `oAddress = addr`, registered.
  - During blanking it holds the next visible address: line start during h-blank, 0 throughout v-blank.
  - No multiplier is used.
- **Raw sync**:
  - hsync_raw is low when 656 ≤ `h` < 752.
  - vsync_raw is low when 490 ≤ `v` < 492.
  - blank_raw is high when visible.
- **Delay line**: {hsync_raw, vsync_raw, blank_raw} pass through a `PIPE_TICKS`-deep shift register that advances on ticks.
  - On each tick, `oHSync`, `oVSync` and `oBlankN` load the delayed values.
  - RGB loads `iPixel[23:16]`, `[15:8]`, `[7:0]` when delayed blank is high, otherwise 0.
- **oVGAClock**: 0 while `phase < CLK_DIV/2`, else 1. Its rising edge therefore falls mid-way through the output-stable period.
- **oFrameStart**: asserted for exactly the tick cycle on which `h` and `v` become (0,0).
- **Reset** (asynchronous, any time including mid-line or mid-frame):
  - `phase`, `h`, `v`, `addr` = 0.
  - Delay line filled with inactive values: sync 1, blank 0.
  - `oHSync` = 1, `oVSync` = 1, `oBlankN` = 0, RGB = 0, `oAddress` = 0, `oFrameStart` = 0, `oVGAClock` = 0.
  - On release, the scan restarts at (0,0). The first tick after release does not pulse `oFrameStart`; the next pulse comes one full frame later.

## Timing
- Frame = 800 × 525 = 420000 ticks = 840000 `iClock` cycles at `CLK_DIV` = 2.
- `oAddress` is stable for `CLK_DIV` consecutive cycles, which satisfies the renderer's 2-cycle path (`~iClock` pixelmap read, `posedge` colour-index register, colour-map ROM) within one tick at `CLK_DIV` = 2.
- RGB, sync and blank for scan position (h,v) appear `PIPE_TICKS` + 1 ticks after `oAddress` shows that position's address. All three are mutually aligned.
- Simultaneous `h` wrap and `v` wrap: `addr` is already 0 (it wrapped at the last visible pixel). `oFrameStart` pulses on that cycle.
- The renderer's per-frame logic sees `oAddress` == 0 for the whole v-blank plus pixel (0,0), about 45 lines. This is intended; the renderer's speed dividers are tuned to it.

## Test plan
- **Reset values**: assert `iResetN` = 0 mid-line at `h` = 300, `v` = 100. All outputs take their reset values immediately, without a clock edge. After release, `oAddress` = 0 and the first `oFrameStart` arrives 840000 cycles later.
- **Horizontal timing**: measure `oHSync` over one line. It is low for exactly 96 ticks (192 cycles); its falling edge is 656 ticks after the first `oBlankN` rise on that line; line period is 1600 cycles.
- **Vertical timing**: `oVSync` is low for exactly 2 lines (3200 cycles) per frame. `oBlankN` is high for 480 lines × 640 ticks per frame. `oFrameStart` period is 840000 cycles.
- **Address sweep**: across one frame `oAddress` takes 0..307199 in order, exactly once each on visible ticks. It holds 640·(v+1) during h-blank of row v < 479 and holds 0 through v-blank.
- **Pixel alignment**: model the renderer as `iPixel` = {5'b0, `oAddress`} registered `PIPE_TICKS` ticks late. At every cycle with `oBlankN` = 1, {R,G,B} equals the address of the displayed (h,v). During blank, RGB = 0.
- **Pipe depth**: repeat the alignment scenario with `PIPE_TICKS` = 3. The sync edges shift by 2 ticks relative to `PIPE_TICKS` = 1, and alignment still holds.

Source files
------------

// File: rtl/vga_scan_controller.sv
// vga_scan_controller
//   Generates VGA scan timing (640x480@60 Hz by default). It presents a linear
//   pixel address to the renderer and takes the renderer's colour back. Sync and
//   blank are delayed by the renderer's pipeline latency so that RGB, sync and
//   blank reach the DAC aligned with each other.
//
// Ports
//   iClock       in   system clock (the only clock)
//   iResetN      in   asynchronous active-low reset
//   iPixel       in   {R,G,B} for the address issued PIPE_TICKS ticks earlier
//   oAddress     out  linear pixel address y*H_VISIBLE+x for the renderer
//   oVGAR/G/B    out  colour to the DAC, forced to 0 during blanking
//   oHSync       out  active-low horizontal sync
//   oVSync       out  active-low vertical sync
//   oBlankN      out  high while a visible pixel is on the DAC
//   oSyncN       out  constant 0 (no sync-on-green)
//   oVGAClock    out  DAC pixel clock, rises mid-way through each pixel
//   oFrameStart  out  one-cycle pulse when pixel (0,0) is issued
module vga_scan_controller #(
  parameter int CLK_DIV    = 2,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_TICKS = 1
) (
  input  logic        iClock,
  input  logic        iResetN,
  input  logic [23:0] iPixel,
  output logic [18:0] oAddress,
  output logic [7:0]  oVGAR,
  output logic [7:0]  oVGAG,
  output logic [7:0]  oVGAB,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oBlankN,
  output logic        oSyncN,
  output logic        oVGAClock,
  output logic        oFrameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int PW      = $clog2(CLK_DIV);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PHASE_HALF = PW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START   = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END     = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START   = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END     = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [18:0]   ADDR_LAST  = 19'(H_VISIBLE * V_VISIBLE - 1);

  // Delay-line entry bit positions and the inactive value (sync high, blank low).
  localparam int DL_HS = 2;
  localparam int DL_VS = 1;
  localparam int DL_BL = 0;
  localparam logic [2:0] DL_IDLE = 3'b110;

  logic [PW-1:0] phase_q, phase_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [18:0]   addr_q, addr_d;
  logic [2:0]    dly_q [PIPE_TICKS];
  logic [2:0]    dly_d [PIPE_TICKS];
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          blank_n_q, blank_n_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          vga_clk_q, vga_clk_d;
  logic          frame_start_q, frame_start_d;

  logic       tick;
  logic       visible;
  logic [2:0] raw;
  logic [2:0] dly_out;

  assign tick    = (phase_q == PHASE_LAST);
  assign visible = (h_q < H_VIS) && (v_q < V_VIS);
  assign raw[DL_HS] = !((h_q >= HS_START) && (h_q < HS_END));
  assign raw[DL_VS] = !((v_q >= VS_START) && (v_q < VS_END));
  assign raw[DL_BL] = visible;
  assign dly_out    = dly_q[PIPE_TICKS-1];

  always_comb begin
    phase_d       = tick ? '0 : phase_q + 1'b1;
    h_d           = h_q;
    v_d           = v_q;
    addr_d        = addr_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_n_d     = blank_n_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    for (int i = 0; i < PIPE_TICKS; i++) dly_d[i] = dly_q[i];

    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        // Only the wrap into (0,0) pulses; leaving reset at (0,0) does not.
        frame_start_d = (v_q == V_LAST);
      end else begin
        h_d = h_q + 1'b1;
      end

      // Counting only visible pixels makes the address hold the next line's
      // start through h-blank and 0 through v-blank without a multiplier.
      if (visible) addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;

      dly_d[0] = raw;
      for (int i = 1; i < PIPE_TICKS; i++) dly_d[i] = dly_q[i-1];

      hsync_d   = dly_out[DL_HS];
      vsync_d   = dly_out[DL_VS];
      blank_n_d = dly_out[DL_BL];
      rgb_d     = dly_out[DL_BL] ? iPixel : 24'h0;
    end

    vga_clk_d = (phase_d >= PHASE_HALF);
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      phase_q       <= '0;
      h_q           <= '0;
      v_q           <= '0;
      addr_q        <= '0;
      for (int i = 0; i < PIPE_TICKS; i++) dly_q[i] <= DL_IDLE;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
      vga_clk_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      h_q           <= h_d;
      v_q           <= v_d;
      addr_q        <= addr_d;
      for (int i = 0; i < PIPE_TICKS; i++) dly_q[i] <= dly_d[i];
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
      vga_clk_q     <= vga_clk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign oAddress    = addr_q;
  assign oVGAR       = rgb_q[23:16];
  assign oVGAG       = rgb_q[15:8];
  assign oVGAB       = rgb_q[7:0];
  assign oHSync      = hsync_q;
  assign oVSync      = vsync_q;
  assign oBlankN     = blank_n_q;
  assign oSyncN      = 1'b0;
  assign oVGAClock   = vga_clk_q;
  assign oFrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller using a reduced raster so whole frames fit in
// a short run: 8 visible + 2 front + 3 sync + 2 back = 15 ticks per line,
// 4 visible + 1 front + 2 sync + 1 back = 8 lines per frame, 120 ticks/frame.
// Two instances run side by side: PIPE_TICKS = 1 and PIPE_TICKS = 3.
module tb_vga_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pix1, pix3;
  logic [18:0] addr1, addr3;
  logic [7:0]  r1, g1, b1, r3, g3, b3;
  logic        hs1, vs1, bn1, sn1, vc1, fs1;
  logic        hs3, vs3, bn3, sn3, vc3, fs3;

  always #5 clk = ~clk;

  vga_scan_controller #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIPE_TICKS(1)
  ) dut1 (
    .iClock(clk), .iResetN(rst_n), .iPixel(pix1), .oAddress(addr1),
    .oVGAR(r1), .oVGAG(g1), .oVGAB(b1), .oHSync(hs1), .oVSync(vs1),
    .oBlankN(bn1), .oSyncN(sn1), .oVGAClock(vc1), .oFrameStart(fs1)
  );

  vga_scan_controller #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIPE_TICKS(3)
  ) dut3 (
    .iClock(clk), .iResetN(rst_n), .iPixel(pix3), .oAddress(addr3),
    .oVGAR(r3), .oVGAG(g3), .oVGAB(b3), .oHSync(hs3), .oVSync(vs3),
    .oBlankN(bn3), .oSyncN(sn3), .oVGAClock(vc3), .oFrameStart(fs3)
  );

  // Renderer model: returns {5'b0, address} PIPE_TICKS ticks after the address
  // was issued. The bench keeps its own tick phase, independent of the DUT.
  logic        tb_phase;
  logic [18:0] rp1_q;
  logic [18:0] rp3_q [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_phase <= 1'b0;
      rp1_q    <= '0;
      for (int i = 0; i < 3; i++) rp3_q[i] <= '0;
    end else begin
      tb_phase <= ~tb_phase;
      if (tb_phase) begin
        rp1_q    <= addr1;
        rp3_q[0] <= addr3;
        rp3_q[1] <= rp3_q[0];
        rp3_q[2] <= rp3_q[1];
      end
    end
  end

  assign pix1 = {5'b0, rp1_q};
  assign pix3 = {5'b0, rp3_q[2]};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int tick;
    int addr;
    bit hs1, vs1, bn1;
    int rgb1;
    bit hs3, vs3, bn3;
    int rgb3;
    bit fs;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int cur;
    int lo_h, bl_h, lo_v, bl_v, n_fs;
    int gap1, gap2, seen;
    string tag;

    // tick: ticks since reset release; outputs show scan position
    // tick-(PIPE_TICKS+1), address shows position tick.
    //            tick addr hs1 vs1 bn1 rgb1 hs3 vs3 bn3 rgb3 fs
    vecs[0]  = '{  0,  0, 1, 1, 0,  0, 1, 1, 0,  0, 0};
    vecs[1]  = '{  1,  1, 1, 1, 0,  0, 1, 1, 0,  0, 0};
    vecs[2]  = '{  2,  2, 1, 1, 1,  0, 1, 1, 0,  0, 0};
    vecs[3]  = '{  5,  5, 1, 1, 1,  3, 1, 1, 1,  1, 0};
    vecs[4]  = '{  9,  8, 1, 1, 1,  7, 1, 1, 1,  5, 0};
    vecs[5]  = '{ 10,  8, 1, 1, 0,  0, 1, 1, 1,  6, 0};
    vecs[6]  = '{ 12,  8, 0, 1, 0,  0, 1, 1, 0,  0, 0};
    vecs[7]  = '{ 14,  8, 0, 1, 0,  0, 0, 1, 0,  0, 0};
    vecs[8]  = '{ 15,  8, 1, 1, 0,  0, 0, 1, 0,  0, 0};
    vecs[9]  = '{ 17, 10, 1, 1, 1,  8, 1, 1, 0,  0, 0};
    vecs[10] = '{ 30, 16, 1, 1, 0,  0, 0, 1, 0,  0, 0};
    vecs[11] = '{ 52, 31, 1, 1, 1, 29, 1, 1, 1, 27, 0};
    vecs[12] = '{ 53,  0, 1, 1, 1, 30, 1, 1, 1, 28, 0};
    vecs[13] = '{ 60,  0, 1, 1, 0,  0, 0, 1, 0,  0, 0};
    vecs[14] = '{ 77,  0, 1, 0, 0,  0, 1, 1, 0,  0, 0};
    vecs[15] = '{100,  0, 1, 0, 0,  0, 1, 0, 0,  0, 0};
    vecs[16] = '{106,  0, 1, 0, 0,  0, 0, 0, 0,  0, 0};
    vecs[17] = '{107,  0, 1, 1, 0,  0, 1, 0, 0,  0, 0};
    vecs[18] = '{120,  0, 1, 1, 0,  0, 0, 1, 0,  0, 1};
    vecs[19] = '{122,  2, 1, 1, 1,  0, 1, 1, 0,  0, 0};
    vecs[20] = '{123,  3, 1, 1, 1,  1, 1, 1, 0,  0, 0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table walk: tick n is sampled 1 time unit after posedge 2n.
    cur = 0;
    foreach (vecs[i]) begin
      repeat (2 * (vecs[i].tick - cur)) @(posedge clk);
      if (vecs[i].tick != cur || i == 0) #1;
      cur = vecs[i].tick;
      tag = $sformatf("t%0d", cur);
      chk({tag, " addr1"}, int'(addr1), vecs[i].addr);
      chk({tag, " addr3"}, int'(addr3), vecs[i].addr);
      chk({tag, " hs1"}, int'(hs1), int'(vecs[i].hs1));
      chk({tag, " vs1"}, int'(vs1), int'(vecs[i].vs1));
      chk({tag, " bn1"}, int'(bn1), int'(vecs[i].bn1));
      chk({tag, " rgb1"}, int'({r1, g1, b1}), vecs[i].rgb1);
      chk({tag, " hs3"}, int'(hs3), int'(vecs[i].hs3));
      chk({tag, " vs3"}, int'(vs3), int'(vecs[i].vs3));
      chk({tag, " bn3"}, int'(bn3), int'(vecs[i].bn3));
      chk({tag, " rgb3"}, int'({r3, g3, b3}), vecs[i].rgb3);
      chk({tag, " fs1"}, int'(fs1), int'(vecs[i].fs));
      chk({tag, " fs3"}, int'(fs3), int'(vecs[i].fs));
      $display("vector tick=%0d addr=%0d hs1=%0b vs1=%0b bn1=%0b rgb1=%0d hs3=%0b bn3=%0b rgb3=%0d fs=%0b",
               cur, addr1, hs1, vs1, bn1, {r1, g1, b1}, hs3, bn3, {r3, g3, b3}, fs1);
    end

    // Pixel clock: low in the first half of a pixel, high in the second.
    chk("vgaclk_lo", int'(vc1), 0);
    chk("sync_n", int'(sn1), 0);
    @(posedge clk); #1;
    chk("vgaclk_hi", int'(vc1), 1);
    chk("vgaclk_hi3", int'(vc3), 1);
    $display("vgaclock checks done");

    // One line period starting on a tick edge (rows 0/1 are both visible).
    lo_h = 0; bl_h = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (!hs1) lo_h++;
      if (bn1) bl_h++;
    end
    chk("hsync_low_cycles", lo_h, 6);
    chk("blank_hi_line", bl_h, 16);
    $display("line: hsync low %0d cycles, blank high %0d cycles", lo_h, bl_h);

    // One frame period.
    lo_v = 0; bl_v = 0; n_fs = 0;
    for (int c = 0; c < 240; c++) begin
      @(posedge clk); #1;
      if (!vs1) lo_v++;
      if (bn1) bl_v++;
      if (fs1) n_fs++;
    end
    chk("vsync_low_cycles", lo_v, 60);
    chk("blank_hi_frame", bl_v, 64);
    chk("fs_per_frame", n_fs, 1);
    $display("frame: vsync low %0d cycles, blank high %0d, fs pulses %0d", lo_v, bl_v, n_fs);

    // Asynchronous reset mid-scan, away from any clock edge.
    repeat (47) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_addr1", int'(addr1), 0);
    chk("rst_hs1", int'(hs1), 1);
    chk("rst_vs1", int'(vs1), 1);
    chk("rst_bn1", int'(bn1), 0);
    chk("rst_rgb1", int'({r1, g1, b1}), 0);
    chk("rst_fs1", int'(fs1), 0);
    chk("rst_vc1", int'(vc1), 0);
    chk("rst_hs3", int'(hs3), 1);
    chk("rst_bn3", int'(bn3), 0);
    chk("rst_addr3", int'(addr3), 0);
    $display("async reset: addr=%0d hs=%0b vs=%0b bn=%0b rgb=%0d", addr1, hs1, vs1, bn1, {r1, g1, b1});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Address sweep over the first frame, plus the first frame-start gap.
    gap1 = 0; seen = 0;
    for (int c = 1; c <= 600 && !seen; c++) begin
      @(posedge clk); #1;
      if (c % 2 == 0 && c < 240) begin
        int n, hp, vp, exp_a;
        n  = c / 2;
        hp = n % 15;
        vp = (n / 15) % 8;
        if (hp < 8 && vp < 4) exp_a = vp * 8 + hp;
        else if (vp < 3)      exp_a = (vp + 1) * 8;
        else                  exp_a = 0;
        chk($sformatf("sweep t%0d", n), int'(addr1), exp_a);
      end
      if (fs1) begin
        gap1 = c;
        seen = 1;
      end
    end
    chk("fs_first_gap", gap1, 240);
    $display("first frame start %0d cycles after release", gap1);

    gap2 = 0; seen = 0;
    for (int c = 1; c <= 600 && !seen; c++) begin
      @(posedge clk); #1;
      if (fs1) begin
        gap2 = c;
        seen = 1;
      end
    end
    chk("fs_period", gap2, 240);
    $display("frame start period %0d cycles", gap2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
